// File: rtl/step_decoder.sv
// ---------------------------------------------------------------------------
// step_decoder : registered control-step counter with one-hot T-state strobes
// Optional macro STEP_DECODER_TERM_EN adds a programmable terminal step. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_decoder #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  clr,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  oe,
`ifdef STEP_DECODER_TERM_EN
  input  logic [SEL_W-1:0]      term,
`endif
  output logic [2**SEL_W-1:0]   m,
  output logic [SEL_W-1:0]      step,
  output logic                  wrap
);

  localparam logic [SEL_W-1:0] C_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] C_ONES = '1;

  logic [SEL_W-1:0] r_step;
  logic             r_wrap;
  logic [SEL_W-1:0] w_last;

`ifdef STEP_DECODER_TERM_EN
  assign w_last = term;
`else
  assign w_last = C_ONES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_step <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_step <= sel_in;
      r_wrap <= 1'b0;
    end else if (adv) begin
      // a loaded step above the terminal value rolls over silently
      if (r_step == w_last) begin
        r_step <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_step <= r_step + C_ONE;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  always_comb begin
    m = '0;
    if (oe) m[r_step] = 1'b1;
  end

  assign step = r_step;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_step_decoder.sv
// Scoreboard bench for step_decoder (SEL_W = 3); term tests run when
// STEP_DECODER_TERM_EN is defined.
`default_nettype none

module tb_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0, adv = 1'b0, clr = 1'b0, load = 1'b0, oe = 1'b1;
  logic [2:0] sel_in = '0;
  logic [2:0] term = 3'd7;
  logic [7:0] m;
  logic [2:0] step;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] st;
    logic [7:0] mm;
    logic       w;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  step_decoder #(.SEL_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .clr    (clr),
    .load   (load),
    .sel_in (sel_in),
    .oe     (oe),
`ifdef STEP_DECODER_TERM_EN
    .term   (term),
`endif
    .m      (m),
    .step   (step),
    .wrap   (wrap)
  );

  // Monitor: outputs are valid every cycle; one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (step !== e.st || m !== e.mm || wrap !== e.w) begin
        failures++;
        $display("FAIL %s: got step=%0d m=%02h wrap=%0b, want step=%0d m=%02h wrap=%0b",
                 e.nm, step, m, wrap, e.st, e.mm, e.w);
      end
    end
  end

  // One clock: apply controls, take the edge, release, optionally change oe,
  // then queue the hand-computed result.
  task automatic cyc(input logic r, input logic a, input logic c, input logic l,
                     input logic [2:0] s, input logic oe_n,
                     input logic [2:0] es, input logic [7:0] em, input logic ew,
                     input string nm);
    exp_t x;
    rst = r; adv = a; clr = c; load = l; sel_in = s;
    @(posedge clk); #1;
    rst = 1'b0; adv = 1'b0; clr = 1'b0; load = 1'b0;
    oe = oe_n;
    x.st = es; x.mm = em; x.w = ew; x.nm = nm;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle hold
    cyc(1,0,0,0,0,1, 0, 8'h01, 0, "reset1");
    cyc(1,0,0,0,0,1, 0, 8'h01, 0, "reset2");
    cyc(0,0,0,0,0,1, 0, 8'h01, 0, "hold1");
    cyc(0,0,0,0,0,1, 0, 8'h01, 0, "hold2");
    // full count with wrap
    cyc(0,1,0,0,0,1, 1, 8'h02, 0, "cnt1");
    cyc(0,1,0,0,0,1, 2, 8'h04, 0, "cnt2");
    cyc(0,1,0,0,0,1, 3, 8'h08, 0, "cnt3");
    cyc(0,1,0,0,0,1, 4, 8'h10, 0, "cnt4");
    cyc(0,1,0,0,0,1, 5, 8'h20, 0, "cnt5");
    cyc(0,1,0,0,0,1, 6, 8'h40, 0, "cnt6");
    cyc(0,1,0,0,0,1, 7, 8'h80, 0, "cnt7");
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "cnt_wrap");
    cyc(0,1,0,0,0,1, 1, 8'h02, 0, "cnt_after_wrap");
    cyc(0,0,0,0,0,1, 1, 8'h02, 0, "hold_after_cnt");
    // priority at step 5
    cyc(0,0,0,1,5,1, 5, 8'h20, 0, "load5");
    cyc(0,1,1,1,3,1, 0, 8'h01, 0, "clr_over_load_adv");
    cyc(0,1,0,1,3,1, 3, 8'h08, 0, "load_over_adv");
    // output gating
    cyc(0,0,0,1,2,0, 2, 8'h00, 0, "gate_load2");
    cyc(0,1,0,0,0,0, 3, 8'h00, 0, "gate_adv3");
    cyc(0,1,0,0,0,0, 4, 8'h00, 0, "gate_adv4");
    cyc(0,0,0,0,0,1, 4, 8'h10, 0, "oe_on");
    // mid-sequence reset
    cyc(0,1,0,0,0,1, 5, 8'h20, 0, "pre_rst5");
    cyc(0,1,0,0,0,1, 6, 8'h40, 0, "pre_rst6");
    cyc(1,1,0,0,0,1, 0, 8'h01, 0, "rst_over_adv");
    // wrap is a single pulse; clr at LAST is not a wrap
    cyc(0,0,0,1,7,1, 7, 8'h80, 0, "load7");
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "wrap_from_load");
    cyc(0,0,0,0,0,1, 0, 8'h01, 0, "wrap_drops");
    cyc(0,0,0,1,7,1, 7, 8'h80, 0, "load7b");
    cyc(0,1,1,0,0,1, 0, 8'h01, 0, "clr_at_last");
`ifdef STEP_DECODER_TERM_EN
    term = 3'd4;
    cyc(0,1,0,0,0,1, 1, 8'h02, 0, "t4_1");
    cyc(0,1,0,0,0,1, 2, 8'h04, 0, "t4_2");
    cyc(0,1,0,0,0,1, 3, 8'h08, 0, "t4_3");
    cyc(0,1,0,0,0,1, 4, 8'h10, 0, "t4_4");
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "t4_wrap");
    cyc(0,1,0,0,0,1, 1, 8'h02, 0, "t4_again");
    cyc(0,0,0,1,6,1, 6, 8'h40, 0, "t4_load6");
    cyc(0,1,0,0,0,1, 7, 8'h80, 0, "t4_above7");
    cyc(0,1,0,0,0,1, 0, 8'h01, 0, "t4_rollover_nowrap");
    term = 3'd0;
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "t0_a");
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "t0_b");
    cyc(0,1,0,0,0,1, 0, 8'h01, 1, "t0_c");
    term = 3'd7;
    cyc(0,0,0,0,0,1, 0, 8'h01, 0, "t0_idle");
`endif
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_decoder.md
# step_decoder

Registered control-step sequencer with a parametrised one-hot decoder. It holds a SEL_W-bit step counter and drives a one-hot strobe bus of 2**SEL_W lines selected by the current step. It sits between the instruction register and the control-signal matrix of the 8-bit CPU and generates the T-state strobes that sequence each instruction. Compared with the fixed 3-to-8 combinational decoder, it is generalised in width and adds counting, load, early clear, a wrap pulse and an optional programmable terminal step.

## Interface
- SEL_W, default 3: width of the step counter and of the select value; the strobe bus is 2**SEL_W wide. Legal values are 1 to 5.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- adv  in  1  advance the counter by one step this cycle.
- clr  in  1  early end-of-instruction; the step returns to 0.
- load  in  1  load the step from sel_in.
- sel_in  in  SEL_W  step value used by load.
- oe  in  1  output enable (positive logic); gates the strobe bus.
- term  in  SEL_W  terminal step. This port exists only with STEP_DECODER_TERM_EN.
- m  out  2**SEL_W  one-hot strobe bus.
- step  out  SEL_W  current step (registered).
- wrap  out  1  one-cycle pulse after the counter wraps from the terminal step to 0.

## Operation
- State consists of the step register and the wrap register only.
- Update priority on each rising edge: rst > clr > load > adv > hold.
  - rst: step <= 0, wrap <= 0.
  - clr: step <= 0, wrap <= 0. A clear is not counted as a wrap.
  - load: step <= sel_in, wrap <= 0. adv is ignored in the same cycle.
  - adv:
    - If step == LAST: step <= 0, wrap <= 1.
    - Otherwise: step <= step + 1, wrap <= 0.
  - No control input active: step holds, wrap <= 0.
- LAST is 2**SEL_W − 1 by default, or term with STEP_DECODER_TERM_EN.
- Step arithmetic is modulo 2**SEL_W; there is no carry out.
- Decode is combinational from the registered step:
  - With oe = 1: m = 1 << step, so exactly one bit is set.
  - With oe = 0: m = 0.
- oe does not affect counting. The step advances while the outputs are gated off.
- A load of a value above LAST is accepted. The counter then advances to 2**SEL_W − 1, wraps to 0 through the modulo arithmetic, and raises no wrap pulse unless the step equals LAST at the time of the advance.

## Timing
- Reset values: step = 0, wrap = 0. The value of m follows oe: 1 (bit 0 set) when oe = 1, and 0 when oe = 0.
- Latency from adv, clr or load to step and m is 1 cycle, visible after the capturing edge.
- Latency from oe to m is 0 cycles (combinational).
- wrap is high for exactly the one cycle in which step has just become 0 through an adv from LAST.
  - With adv held continuously, wrap pulses once every LAST + 1 cycles.
- rst asserted mid-sequence overrides every other input on that edge. No strobe other than m[0] appears after the edge.
- clr and load asserted together: clr wins, and step = 0.
- adv asserted on consecutive cycles advances one step per cycle with no bubbles.

## Configuration
- STEP_DECODER_TERM_EN defined:
  - Adds the term input.
  - The counter wraps after the step equals term, which shortens the instruction cycle.
  - term is sampled on every edge and may change between instructions.
  - term = 0 means every adv wraps immediately, with wrap pulsing on each advance.
- STEP_DECODER_TERM_EN undefined:
  - No term port.
  - LAST is the constant 2**SEL_W − 1.
  - Behaviour otherwise matches the defined case with term = all ones.

## Test plan
- Reset: SEL_W = 3, oe = 1, rst high for 2 cycles, then released -> step = 0, m = 8'h01, wrap = 0; holds with no control inputs active.
- Full count: SEL_W = 3, adv held for 9 cycles -> m steps 01, 02, 04 … 80, 01, 02; wrap = 1 only in the cycle step returns to 0.
- Priority: at step = 5, assert clr, load (sel_in = 3) and adv together -> step = 0, wrap = 0. Next cycle load (sel_in = 3) with adv -> step = 3, m = 8'h08.
- Output gating: oe = 0 while advancing from step 2 to step 4 -> m = 0 throughout, step = 4. oe = 1 -> m = 8'h10 in the same cycle.
- Mid-sequence reset: at step = 6, rst and adv high together -> step = 0, wrap = 0, m = 8'h01 the next cycle.
- Terminal step (STEP_DECODER_TERM_EN): SEL_W = 4, term = 4, adv held -> step sequence 0, 1, 2, 3, 4, 0, with wrap pulsing every 5 cycles. With term = 0 -> step stays 0 and wrap stays high every cycle.
